// File: rtl/handshake_chk_pkg.sv
// Shared types and helpers for the handshake window checker.
//   ch_state_e  : per-channel FSM state (CH_IDLE / CH_WAIT)
//   ch_result_t : per-channel outcome pulses (pass / early / timeout)
//   params_legal: elaboration-time parameter legality check
package handshake_chk_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_WAIT = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic pass;
    logic early;
    logic timeout;
  } ch_result_t;

  function automatic bit params_legal(input int unsigned n_ch,
                                      input int unsigned min_dly,
                                      input int unsigned max_dly,
                                      input int unsigned cnt_w);
    return (n_ch >= 1) && (n_ch <= 32) && (min_dly >= 1) &&
           (max_dly >= min_dly) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/handshake_chk_channel.sv
// One req/ack channel: IDLE/WAIT FSM, delay timer and registered outcome pulses.
// Optional assertions are compiled in with `define HANDSHAKE_CHK_SVA_EN.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   chk_en       : check enable; low drops any pending attempt silently
//   req, ack     : channel handshake inputs
//   result       : registered outcome pulses (one cycle after the deciding cycle)
//   result_c     : combinational outcome of the current (deciding) cycle
//   busy         : waiting for an ack
module handshake_chk_channel
  import handshake_chk_pkg::*;
#(
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chk_en,
  input  logic       req,
  input  logic       ack,
  output ch_result_t result,
  output ch_result_t result_c,
  output logic       busy
);

  localparam int unsigned TW = $clog2(MAX_DLY + 2);

  ch_state_e  state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [TW-1:0] dly;
  ch_result_t result_q;

  // Delay of the current cycle relative to the accepting cycle.
  assign dly = timer + TW'(1);

  // State, timer and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CH_IDLE;
      timer    <= '0;
      result_q <= '0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      result_q <= result_c;
    end
  end

  // Next-state and outcome decode.
  always_comb begin
    state_next = state;
    timer_next = timer;
    result_c   = '0;
    if (!chk_en) begin
      state_next = CH_IDLE;
      timer_next = '0;
    end else begin
      case (state)
        CH_IDLE: begin
          if (req) begin
            state_next = CH_WAIT;
            timer_next = '0;
          end
        end
        CH_WAIT: begin
          timer_next = timer + TW'(1);
          if (ack) begin
            if (dly < TW'(MIN_DLY)) result_c.early = 1'b1;
            else                    result_c.pass  = 1'b1;
            state_next = CH_IDLE;
            timer_next = '0;
          end else if (dly == TW'(MAX_DLY)) begin
            result_c.timeout = 1'b1;
            state_next       = CH_IDLE;
            timer_next       = '0;
          end
        end
        default: begin
          state_next = CH_IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  assign result = result_q;
  assign busy   = (state == CH_WAIT);

`ifdef HANDSHAKE_CHK_SVA_EN
  logic accepted;
  assign accepted = (state == CH_IDLE) && req;

  property p_window;
    @(posedge clk) disable iff (reset || !chk_en)
      accepted |-> ##[MIN_DLY:MAX_DLY] ack;
  endproperty

  property p_pass_seen;
    @(posedge clk) disable iff (reset || !chk_en)
      result_q.pass;
  endproperty

  // An in-window ack must be reported as a pass and nothing else.
  property p_pulse_agrees;
    @(posedge clk) disable iff (reset || !chk_en)
      (busy && ack && (dly >= TW'(MIN_DLY)) && (dly <= TW'(MAX_DLY)))
        |=> (result_q == '{pass: 1'b1, early: 1'b0, timeout: 1'b0});
  endproperty

  a_window:        assert property (p_window);
  c_pass:          cover  property (p_pass_seen);
  a_pulse_agrees:  assert property (p_pulse_agrees);
`endif

endmodule

// File: rtl/handshake_window_checker.sv
// Multi-channel req/ack window monitor: every accepted req must see ack
// within MIN_DLY..MAX_DLY cycles. Optional SVA checks via HANDSHAKE_CHK_SVA_EN.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   chk_en                      : global check enable (low acts as disable-iff)
//   clear                       : clears counters and err_sticky (wins over events)
//   req, ack     [N_CH]         : per-channel handshake inputs
//   pass, viol_early, viol_timeout [N_CH] : one-cycle outcome pulses
//   busy         [N_CH]         : channel waiting for ack
//   err_sticky                  : any violation since last clear/reset
//   pass_cnt, viol_cnt [CNT_W]  : saturating event counters
module handshake_window_checker
  import handshake_chk_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chk_en,
  input  logic             clear,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  ack,
  output logic [N_CH-1:0]  pass,
  output logic [N_CH-1:0]  viol_early,
  output logic [N_CH-1:0]  viol_timeout,
  output logic [N_CH-1:0]  busy,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int unsigned PW = $clog2(N_CH + 1);
  localparam int unsigned SW = CNT_W + PW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (!params_legal(N_CH, MIN_DLY, MAX_DLY, CNT_W)) begin : g_param_err
    $error("handshake_window_checker: illegal parameters");
  end

  ch_result_t res   [N_CH];
  ch_result_t res_c [N_CH];
  logic [PW-1:0] pass_inc, viol_inc;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    handshake_chk_channel #(
      .MIN_DLY (MIN_DLY),
      .MAX_DLY (MAX_DLY)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .chk_en   (chk_en),
      .req      (req[i]),
      .ack      (ack[i]),
      .result   (res[i]),
      .result_c (res_c[i]),
      .busy     (busy[i])
    );
    assign pass[i]         = res[i].pass;
    assign viol_early[i]   = res[i].early;
    assign viol_timeout[i] = res[i].timeout;
  end

  // Popcount of this cycle's decisions, so counters line up with the pulses.
  always_comb begin
    pass_inc = '0;
    viol_inc = '0;
    for (int i = 0; i < N_CH; i++) begin
      pass_inc = pass_inc + PW'(res_c[i].pass);
      viol_inc = viol_inc + PW'(res_c[i].early | res_c[i].timeout);
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [PW-1:0]    inc);
    logic [SW-1:0] sum;
    sum = SW'(cnt) + SW'(inc);
    return (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  // Counters and sticky flag; clear takes priority over same-cycle events.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pass_cnt   <= '0;
      viol_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      pass_cnt   <= sat_add(pass_cnt, pass_inc);
      viol_cnt   <= sat_add(viol_cnt, viol_inc);
      err_sticky <= err_sticky | (viol_inc != '0);
    end
  end

endmodule

// File: tb/tb_handshake_window_checker.sv
// Self-checking bench for handshake_window_checker: directed scenarios plus
// randomized traffic compared against a cycle-count reference model.
module tb_handshake_window_checker;

  localparam int N_CH    = 4;
  localparam int MIN_DLY = 2;
  localparam int MAX_DLY = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, chk_en, clear;
  logic [N_CH-1:0] req, ack;
  logic [N_CH-1:0] pass, viol_early, viol_timeout, busy;
  logic err_sticky;
  logic [CNT_W-1:0] pass_cnt, viol_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: each pending attempt remembers the cycle it was accepted.
  bit m_pend [N_CH];
  int m_acc  [N_CH];
  int cyc = 0;
  bit [N_CH-1:0] m_pass, m_early, m_tmo, m_busy;
  int m_pcnt, m_vcnt;
  bit m_err;

  always #5 clk = ~clk;

  handshake_window_checker #(
    .N_CH    (N_CH),
    .MIN_DLY (MIN_DLY),
    .MAX_DLY (MAX_DLY),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .chk_en       (chk_en),
    .clear        (clear),
    .req          (req),
    .ack          (ack),
    .pass         (pass),
    .viol_early   (viol_early),
    .viol_timeout (viol_timeout),
    .busy         (busy),
    .err_sticky   (err_sticky),
    .pass_cnt     (pass_cnt),
    .viol_cnt     (viol_cnt)
  );

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    int np, nv, d;
    @(posedge clk);
    np = 0;
    nv = 0;
    m_pass  = '0;
    m_early = '0;
    m_tmo   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (reset || !chk_en) begin
        m_pend[i] = 1'b0;
      end else if (m_pend[i]) begin
        d = cyc - m_acc[i];
        if (ack[i]) begin
          if (d < MIN_DLY) m_early[i] = 1'b1;
          else             m_pass[i]  = 1'b1;
          m_pend[i] = 1'b0;
        end else if (d == MAX_DLY) begin
          m_tmo[i]  = 1'b1;
          m_pend[i] = 1'b0;
        end
      end else if (req[i]) begin
        m_pend[i] = 1'b1;
        m_acc[i]  = cyc;
      end
      m_busy[i] = m_pend[i];
      np += int'(m_pass[i]);
      nv += int'(m_early[i] | m_tmo[i]);
    end
    if (reset || clear) begin
      m_pcnt = 0;
      m_vcnt = 0;
      m_err  = 1'b0;
    end else begin
      m_pcnt = (m_pcnt + np > CNT_MAX) ? CNT_MAX : m_pcnt + np;
      m_vcnt = (m_vcnt + nv > CNT_MAX) ? CNT_MAX : m_vcnt + nv;
      m_err  = m_err || (nv > 0);
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    reset  = 1'b0;
    chk_en = 1'b1;
    clear  = 1'b0;
    req    = '0;
    ack    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; chk_en = 1'b1; clear = 1'b0; req = '1; ack = '1;
    tick();
    tick();
    checks++;
    if ({pass, viol_early, viol_timeout, busy, err_sticky, pass_cnt, viol_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got pass=%b early=%b tmo=%b busy=%b err=%b pc=%0d vc=%0d want all 0",
               pass, viol_early, viol_timeout, busy, err_sticky, pass_cnt, viol_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_pass();
    do_reset();
    req = 4'b0001; tick();                 // now cycle 1
    req = '0;
    checks++;
    if (busy !== 4'b0001) begin failures++; $display("FAIL pass_busy got %b want 0001", busy); end
    tick(); tick();                        // cycle 3
    ack = 4'b0001; tick();                 // cycle 4
    ack = '0;
    checks++;
    if (pass !== 4'b0001 || pass_cnt !== 4'd1 || busy !== 4'b0000) begin
      failures++;
      $display("FAIL pass_mid got pass=%b cnt=%0d busy=%b want 0001 1 0000", pass, pass_cnt, busy);
    end
    // Restart in the pulse cycle, then ack exactly at MAX_DLY.
    req = 4'b0001; tick();                 // accepted at cycle 4, now 5
    req = '0;
    repeat (MAX_DLY - 1) tick();           // cycle 9, d = 5
    ack = 4'b0001; tick();
    ack = '0;
    checks++;
    if (pass !== 4'b0001 || viol_timeout !== 4'b0000 || pass_cnt !== 4'd2) begin
      failures++;
      $display("FAIL pass_at_max got pass=%b tmo=%b cnt=%0d want 0001 0000 2", pass, viol_timeout, pass_cnt);
    end
  endtask

  task automatic test_early();
    do_reset();
    req = 4'b0010; tick();
    req = '0; ack = 4'b0010; tick();       // d = 1 < MIN_DLY
    ack = '0;
    checks++;
    if (viol_early !== 4'b0010 || pass !== 4'b0000 || err_sticky !== 1'b1 || viol_cnt !== 4'd1) begin
      failures++;
      $display("FAIL early got early=%b pass=%b err=%b vc=%0d want 0010 0000 1 1",
               viol_early, pass, err_sticky, viol_cnt);
    end
  endtask

  task automatic test_ack_with_req();
    do_reset();
    req = 4'b0001; ack = 4'b0001; tick();  // d = 0 ack ignored
    req = '0; ack = '0;
    checks++;
    if (busy !== 4'b0001 || viol_early !== 4'b0000) begin
      failures++;
      $display("FAIL ack_d0 got busy=%b early=%b want 0001 0000", busy, viol_early);
    end
    tick();                                // cycle 2
    ack = 4'b0001; tick();
    ack = '0;
    checks++;
    if (pass !== 4'b0001 || viol_early !== 4'b0000) begin
      failures++;
      $display("FAIL ack_d0_then_pass got pass=%b early=%b want 0001 0000", pass, viol_early);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0100; tick();
    req = '0;
    repeat (MAX_DLY) tick();               // cycle 6
    checks++;
    if (viol_timeout !== 4'b0100 || busy !== 4'b0000 || viol_cnt !== 4'd1) begin
      failures++;
      $display("FAIL timeout got tmo=%b busy=%b vc=%0d want 0100 0000 1", viol_timeout, busy, viol_cnt);
    end
    req = 4'b0100; tick();                 // cycle 7
    req = '0;
    checks++;
    if (busy !== 4'b0100 || viol_timeout !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_rearm got busy=%b tmo=%b want 0100 0000", busy, viol_timeout);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b1001; tick();
    req = '0; tick();
    ack = 4'b1001; tick();
    ack = '0;
    checks++;
    if (pass !== 4'b1001 || pass_cnt !== 4'd2) begin
      failures++;
      $display("FAIL same_cycle_pass got pass=%b cnt=%0d want 1001 2", pass, pass_cnt);
    end
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      req = '1; tick();
      req = '0; tick();
      ack = '1; tick();
      ack = '0;
      want = (4 * k > CNT_MAX) ? CNT_MAX : 4 * k;
      checks++;
      if (pass !== 4'b1111 || pass_cnt !== CNT_W'(want)) begin
        failures++;
        $display("FAIL saturation round=%0d got pass=%b cnt=%0d want 1111 %0d", k, pass, pass_cnt, want);
      end
    end
  endtask

  task automatic test_chk_en_drop();
    do_reset();
    req = 4'b0100; tick();
    req = '0; ack = 4'b0100; tick();       // early on ch2 -> vc=1, err=1
    ack = '0;
    req = 4'b0001; tick();                 // ch0 attempt, cycle 1
    req = '0; tick();                      // cycle 2
    chk_en = 1'b0; tick();                 // cycle 3
    chk_en = 1'b1;
    checks++;
    if (busy !== 4'b0000 || {pass, viol_early, viol_timeout} !== '0 ||
        viol_cnt !== 4'd1 || err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL chk_en_drop got busy=%b pulses=%b vc=%0d err=%b want 0 0 1 1",
               busy, {pass, viol_early, viol_timeout}, viol_cnt, err_sticky);
    end
    for (int c = 0; c < MAX_DLY + 1; c++) begin
      tick();
      checks++;
      if ({pass, viol_early, viol_timeout} !== '0) begin
        failures++;
        $display("FAIL chk_en_no_pulse c=%0d got %b want 0", c, {pass, viol_early, viol_timeout});
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001; tick();
    req = '0; tick(); tick();              // cycle 3
    reset = 1'b1; tick();
    reset = 1'b0;
    checks++;
    if ({pass, viol_early, viol_timeout, busy, err_sticky, pass_cnt, viol_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b pulses=%b want all 0", busy, {pass, viol_early, viol_timeout});
    end
    for (int c = 0; c < MAX_DLY + 1; c++) begin
      tick();
      checks++;
      if ({pass, viol_early, viol_timeout} !== '0) begin
        failures++;
        $display("FAIL reset_mid_no_pulse c=%0d got %b want 0", c, {pass, viol_early, viol_timeout});
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    req = 4'b1000; tick();
    req = '0;
    repeat (MAX_DLY) tick();               // ch3 timeout -> vc=1 err=1
    req = 4'b0010; tick();
    req = '0; ack = 4'b0010; clear = 1'b1; tick();
    ack = '0; clear = 1'b0;
    checks++;
    if (viol_early !== 4'b0010 || viol_cnt !== 4'd0 || err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL clear_vs_event got early=%b vc=%0d err=%b want 0010 0 0", viol_early, viol_cnt, err_sticky);
    end
    tick();
    checks++;
    if (viol_cnt !== 4'd0 || err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL clear_after got vc=%0d err=%b want 0 0", viol_cnt, err_sticky);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(199) == 0);
      chk_en = ($urandom_range(29) != 0);
      clear  = ($urandom_range(49) == 0);
      req    = N_CH'($urandom);
      for (int i = 0; i < N_CH; i++) ack[i] = ($urandom_range(3) == 0);
      tick();
      checks++;
      if ({pass, viol_early, viol_timeout, busy} !== {m_pass, m_early, m_tmo, m_busy}) begin
        failures++;
        $display("FAIL rand_pulses cyc=%0d got p=%b e=%b t=%b b=%b want p=%b e=%b t=%b b=%b",
                 cyc, pass, viol_early, viol_timeout, busy, m_pass, m_early, m_tmo, m_busy);
      end
      checks++;
      if (pass_cnt !== CNT_W'(m_pcnt) || viol_cnt !== CNT_W'(m_vcnt) || err_sticky !== m_err) begin
        failures++;
        $display("FAIL rand_counters cyc=%0d got pc=%0d vc=%0d err=%b want pc=%0d vc=%0d err=%b",
                 cyc, pass_cnt, viol_cnt, err_sticky, m_pcnt, m_vcnt, m_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      m_pend[i] = 1'b0;
      m_acc[i]  = 0;
    end
    m_pcnt = 0;
    m_vcnt = 0;
    m_err  = 1'b0;
    idle_inputs();
    test_reset();
    test_pass();
    test_early();
    test_ack_with_req();
    test_timeout();
    test_back_to_back();
    test_saturation();
    test_chk_en_drop();
    test_reset_mid();
    test_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
